// File: rtl/dehaze_pkg.sv
// Shared defaults for the dehazing pipeline stages.
// Also holds the counter-width helper used by the window generator.
package dehaze_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int IMG_W_DEF  = 640;
    localparam int IMG_H_DEF  = 480;

    // Counter width that can hold 0..n-1; never narrower than one bit.
    function automatic int ctrWidth(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel stream in, 3x3 window out, for the window generator.
// The master side drives pixels; the slave side is the generator itself.
interface window_gen_3x3_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_pixel;
    logic              out_valid;
    logic              out_sof;
    logic [DATA_W-1:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  out_valid, out_sof, w1, w2, w3, w4, w5, w6, w7, w8, w9
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output out_valid, out_sof, w1, w2, w3, w4, w5, w6, w7, w8, w9
    );
endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// Single-port line store: combinational read, write on enable.
// Reading and writing the same address in one cycle returns the old word.
module line_buffer #(
    parameter int DEPTH  = 640,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_wrData,
    output logic [WIDTH-1:0]  o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdData = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_addr] <= i_wrData;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator feeding the weighted 3x3 filters.
// Two line buffers hold rows r-1 and r-2; only fully interior windows are flagged valid.
module window_gen_3x3
    import dehaze_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    window_gen_3x3_if.slave  io_win
);

    localparam int COL_W = ctrWidth(IMG_W);
    localparam int ROW_W = ctrWidth(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_outValid;
    logic              r_outSof;
    logic [DATA_W-1:0] r_w1, r_w2, r_w3, r_w4, r_w5, r_w6, r_w7, r_w8, r_w9;

    logic              w_accept;
    logic [COL_W-1:0]  w_curCol;
    logic [ROW_W-1:0]  w_curRow;
    logic              w_colLast;
    logic              w_rowLast;
    logic [COL_W-1:0]  w_nextCol;
    logic [ROW_W-1:0]  w_nextRow;
    logic              w_winValid;
    logic              w_winSof;
    logic [DATA_W-1:0] w_lb0Rd;
    logic [DATA_W-1:0] w_lb1Rd;

    // A start-of-frame marker overrides the counters so a mid-frame marker resyncs at once.
    assign w_accept   = io_win.in_valid;
    assign w_curCol   = io_win.in_sof ? '0 : r_col;
    assign w_curRow   = io_win.in_sof ? '0 : r_row;
    assign w_colLast  = (w_curCol == COL_LAST);
    assign w_rowLast  = (w_curRow == ROW_LAST);
    assign w_nextCol  = w_colLast ? '0 : COL_W'(w_curCol + 1'b1);
    assign w_nextRow  = w_colLast ? (w_rowLast ? '0 : ROW_W'(w_curRow + 1'b1)) : w_curRow;
    assign w_winValid = (w_curRow >= ROW_TWO) && (w_curCol >= COL_TWO);
    assign w_winSof   = (w_curRow == ROW_TWO) && (w_curCol == COL_TWO);

    line_buffer #(
        .DEPTH  (IMG_W),
        .WIDTH  (DATA_W),
        .ADDR_W (COL_W)
    ) u_lb0 (
        .clk      (clk),
        .i_wrEn   (w_accept),
        .i_addr   (w_curCol),
        .i_wrData (io_win.in_pixel),
        .o_rdData (w_lb0Rd)
    );

    // The row falling out of LB0 cascades into LB1, so LB1 always trails by one more row.
    line_buffer #(
        .DEPTH  (IMG_W),
        .WIDTH  (DATA_W),
        .ADDR_W (COL_W)
    ) u_lb1 (
        .clk      (clk),
        .i_wrEn   (w_accept),
        .i_addr   (w_curCol),
        .i_wrData (w_lb0Rd),
        .o_rdData (w_lb1Rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_outValid <= 1'b0;
            r_outSof   <= 1'b0;
            r_w1 <= '0; r_w2 <= '0; r_w3 <= '0;
            r_w4 <= '0; r_w5 <= '0; r_w6 <= '0;
            r_w7 <= '0; r_w8 <= '0; r_w9 <= '0;
        end else if (w_accept) begin
            r_col      <= w_nextCol;
            r_row      <= w_nextRow;
            r_outValid <= w_winValid;
            r_outSof   <= w_winSof;
            r_w1 <= r_w2; r_w2 <= r_w3; r_w3 <= w_lb1Rd;
            r_w4 <= r_w5; r_w5 <= r_w6; r_w6 <= w_lb0Rd;
            r_w7 <= r_w8; r_w8 <= r_w9; r_w9 <= io_win.in_pixel;
        end else begin
            r_outValid <= 1'b0;
            r_outSof   <= 1'b0;
        end
    end

    assign io_win.out_valid = r_outValid;
    assign io_win.out_sof   = r_outSof;
    assign io_win.w1 = r_w1;
    assign io_win.w2 = r_w2;
    assign io_win.w3 = r_w3;
    assign io_win.w4 = r_w4;
    assign io_win.w5 = r_w5;
    assign io_win.w6 = r_w6;
    assign io_win.w7 = r_w7;
    assign io_win.w8 = r_w8;
    assign io_win.w9 = r_w9;

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 neighbourhood generator that sits directly upstream of the weighted 3x3 filter stages in the dehazing pipeline. It takes one raster-order pixel per accepted cycle, buffers the two previous image rows, and presents a registered 3x3 window on nine parallel outputs. The outputs are ordered to connect one-to-one onto the filter's `in1`..`in9`. Only windows that lie fully inside the image are flagged valid, so the filter output image is (IMG_W-2) x (IMG_H-2).

## Interface
Parameters:
- `DATA_W`, 8: pixel width in bits.
- `IMG_W`, 640: pixels per line (>= 3).
- `IMG_H`, 480: lines per frame (>= 3).

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `in_valid`  in  1  `in_pixel` is accepted this cycle. There is no backpressure.
- `in_sof`  in  1  start of frame. Qualified by `in_valid`; marks the accepted pixel as (row 0, col 0).
- `in_pixel`  in  DATA_W  raster-order pixel.
- `out_valid`  out  1  window outputs are valid this cycle.
- `out_sof`  out  1  first valid window of the frame; only meaningful with `out_valid`.
- `w1`..`w9`  out  DATA_W each  3x3 window, row-major. `w1` is top-left, `w5` is centre, `w9` is bottom-right.

## Operation
- Counters `row` (0..IMG_H-1) and `col` (0..IMG_W-1) give the position of the next accepted pixel.
  - Each accept increments `col`. At IMG_W-1, `col` wraps to 0 and `row` increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0, so back-to-back frames need no gap.
- `in_sof` with `in_valid` forces the current pixel to be (0,0), whatever the counters hold. The counters then become (0,1). This resyncs on a mid-frame `in_sof`.
- There are two line buffers, each IMG_W deep and addressed by `col`:
  - LB0 holds row r-1.
  - LB1 holds row r-2.
- On each accept at `col` c, in the same cycle:
  - Read LB0[c] and LB1[c].
  - Write LB0[c] <= `in_pixel` and LB1[c] <= the old LB0[c]. Reads are read-before-write.
- The window shifts left by one column. The new right column is {LB1[c], LB0[c], `in_pixel`}, i.e. {`w3`, `w6`, `w9`}.
- `out_valid` is registered high in the cycle after an accept where row >= 2 and col >= 2. The window is then centred on pixel (r-1, c-1).
- `out_sof` is registered high with the window for the accepted pixel (2,2).
- On non-accept cycles:
  - `out_valid` and `out_sof` are 0.
  - `w1`..`w9`, counters and buffers hold.
- Line-buffer contents are never cleared. Stale data can only reach `w*`, and is never flagged valid, because of the row/col gating.
- Windows never straddle a line: the col >= 2 gate excludes the two columns that wrapped in from the previous row.

## Timing
- Latency: 1 cycle from the accept of pixel (r,c) to `out_valid` with `w9` = that pixel.
- Throughput: 1 window per cycle under continuous `in_valid`.
- Valid windows per frame: (IMG_W-2) x (IMG_H-2).
- Reset values: `out_valid`=0, `out_sof`=0, `w1`..`w9`=0, `row`=0, `col`=0. Line buffers are not reset.
- Reset mid-frame: outputs drop to 0 asynchronously. After release, the next accepted pixel is (0,0) even without `in_sof`.
- If `in_sof` and a counter wrap fall on the same cycle, `in_sof` wins.

## Structure
- Shared package `dehaze_pkg`: `DATA_W` default and the IMG_W/IMG_H defaults.
- Sub-module `line_buffer`:
  - Parameters: depth IMG_W, width DATA_W.
  - Single port: read-before-write, combinational read, write on enable.
  - Instantiated twice.
- Counters, window registers and valid/sof logic stay in `window_gen_3x3`.

## Test plan
Use IMG_W=4, IMG_H=4, with pixel (r,c) = 4r+c+1.
- Continuous frame with `in_sof` on the first pixel:
  - Exactly 4 `out_valid` pulses.
  - The first pulse is 1 cycle after pixel 11, with `out_sof`=1 and `w1`..`w9` = 1,2,3,5,6,7,9,10,11.
  - The last window is 6,7,8,10,11,12,14,15,16.
- Same frame with `in_valid` deasserted every other cycle: identical 4 windows; `out_valid` is low in gap cycles and `w*` holds.
- Two back-to-back frames with no idle cycle: 8 windows; `out_sof` only on the 1st and 5th.
- Mid-frame `in_sof` after 6 pixels, then a full frame:
  - No window is valid until pixel (2,2) of the new frame.
  - That window is 1,2,3,5,6,7,9,10,11.
- `rst_n` low for 2 cycles after 10 pixels, then a full frame without `in_sof`:
  - `out_valid`/`w*` read 0 during reset.
  - The correct 4 windows follow.
- Minimum size IMG_W=3, IMG_H=3: exactly 1 window, equal to 1..9 in order.
